// File: rtl/urdhva_seq_multiplier.sv
// Purpose: iterative NxN unsigned multiplier, one vertical-and-crosswise column per clock.
// Latency: product valid 2N-1 cycles after operand acceptance; one result per 2N+1 cycles at best.
// Backpressure: in_ready only in IDLE; DONE holds product stable until out_ready.
module urdhva_seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  // carry never exceeds N-1; column sum plus carry never exceeds 2N-1
  localparam int CW   = $clog2(N);
  localparam int TW   = $clog2(2 * N);
  localparam int KW   = $clog2(2 * N);
  localparam int LAST = 2 * N - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     ra_q, rb_q;
  logic [2*N-1:0]   product_q, product_d;
  logic [CW-1:0]    carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;

  logic [TW-1:0]    col_sum;
  logic [TW-1:0]    t_sum;
  logic             last_col;
  logic             accept;

  assign last_col = (k_q == KW'(LAST));
  assign accept   = (state_q == IDLE) && in_valid;

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept in IDLE, walk 2N-1 columns, hold in DONE until consumed
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = COMPUTE;
      COMPUTE: if (last_col)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake outputs decode directly from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Crosswise column k: add every partial product ra[i]&rb[j] with i+j==k, then the running carry
  always_comb begin
    col_sum = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if ((i + j) == int'(k_q)) begin
          col_sum = col_sum + TW'(ra_q[i] & rb_q[j]);
        end
      end
    end
    t_sum = col_sum + TW'(carry_q);
  end

  // Datapath next-state: clear on accept, resolve one product bit per COMPUTE cycle
  always_comb begin
    product_d = product_q;
    carry_d   = carry_q;
    k_d       = k_q;
    if (accept) begin
      product_d = '0;
      carry_d   = '0;
      k_d       = '0;
    end else if (state_q == COMPUTE) begin
      product_d[k_q] = t_sum[0];
      carry_d        = CW'(t_sum >> 1);
      k_d            = k_q + KW'(1);
      // final carry is at most 1 and lands in the top product bit
      if (last_col) begin
        product_d[2*N-1] = t_sum[1];
      end
    end
  end

  // Datapath registers; operands are sampled only on the acceptance cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_q      <= '0;
      rb_q      <= '0;
      product_q <= '0;
      carry_q   <= '0;
      k_q       <= '0;
    end else begin
      if (accept) begin
        ra_q <= a;
        rb_q <= b;
      end
      product_q <= product_d;
      carry_q   <= carry_d;
      k_q       <= k_d;
    end
  end

  assign product = product_q;

endmodule
